// File: rtl/fc_tx_sched_pkg.sv
// Shared constants, 8b/10b byte helper and scheduler state type for the FC TX word scheduler.
// Ordered-set words are big-endian, with the K28.5 comma in byte [31:24].
package fc_tx_sched_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    // Dx.y data byte: y in bits [7:5], x in bits [4:0].
    function automatic logic [7:0] d_byte(input int unsigned x, input int unsigned y);
        return 8'(((y & 32'd7) << 5) | (x & 32'd31));
    endfunction

    localparam logic [31:0] IDLE_WORD = {K28_5, d_byte(21, 4), d_byte(21, 5), d_byte(21, 5)};
    localparam logic [31:0] RRDY_WORD = {K28_5, d_byte(21, 4), d_byte(10, 2), d_byte(10, 2)};

    localparam logic [3:0] K_FILL = 4'b1000;
    localparam logic [3:0] K_DATA = 4'b0000;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FRAME = 2'd1,
        DRAIN = 2'd2
    } tx_sched_state_t;

endpackage

// File: rtl/fc_tx_sched_if.sv
// Avalon-ST frame word stream between the frame source and the TX scheduler.
// The scheduler is the slave; ready is its only output on this bus.
interface fc_tx_sched_if;

    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        startofpacket;
    logic        endofpacket;

    modport master (
        output data,
        output valid,
        output startofpacket,
        output endofpacket,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  startofpacket,
        input  endofpacket,
        output ready
    );

endinterface

// File: rtl/fc_tx_sched_credit.sv
// Saturating up/down counter of outstanding R_RDY requests, with synchronous clear.
// Clear wins; a simultaneous increment and decrement leave the count unchanged.
module fc_tx_sched_credit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fc_tx_sched.sv
// TX word scheduler: shares the single 32-bit TX slot between frames, R_RDY and IDLE fill,
// enforcing a minimum fill gap between frames and never breaking a frame once started.
module fc_tx_sched
    import fc_tx_sched_pkg::*;
#(
    parameter int MIN_FILL = 6,
    parameter int RRDY_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              link_active,
    fc_tx_sched_if.slave      avtx,
    input  logic              rrdy_req,
    output logic [RRDY_W-1:0] rrdy_pending,
    output logic [31:0]       tx_data,
    output logic [3:0]        tx_datak,
    output logic              underrun,
    output logic              drop,
    output logic [31:0]       frames_sent
);

    localparam int GAP_W = (MIN_FILL < 1) ? 1 : $clog2(MIN_FILL + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_FILL);

    tx_sched_state_t state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      tx_data_q, tx_data_d;
    logic [3:0]       tx_datak_q, tx_datak_d;
    logic             underrun_q, underrun_d;
    logic             drop_q, drop_d;
    logic [31:0]      frames_q, frames_d;

    logic             ready_c;
    logic             rrdy_emit;
    logic             fill_rrdy;
    logic [31:0]      fill_data;
    logic             gap_full;
    logic [GAP_W-1:0] gap_step;

    fc_tx_sched_credit #(
        .W (RRDY_W)
    ) u_credit (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (!link_active),
        .inc_i   (rrdy_req),
        .dec_i   (rrdy_emit),
        .count_o (rrdy_pending)
    );

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_data_d  = IDLE_WORD;
        tx_datak_d = K_FILL;
        underrun_d = 1'b0;
        drop_d     = 1'b0;
        frames_d   = frames_q;
        ready_c    = 1'b0;
        rrdy_emit  = 1'b0;

        gap_full  = (gap_q == GAP_MAX);
        gap_step  = gap_full ? gap_q : gap_q + 1'b1;
        // R_RDY is never sent on a down link; the credit counter clears there anyway.
        fill_rrdy = link_active && (rrdy_pending != '0);
        fill_data = fill_rrdy ? RRDY_WORD : IDLE_WORD;

        case (state_q)
            FILL: begin
                if (link_active && avtx.valid && avtx.startofpacket && gap_full) begin
                    ready_c   = 1'b1;
                    tx_data_d = avtx.data;
                    gap_d     = '0;
                    if (avtx.endofpacket) begin
                        frames_d = frames_q + 32'd1;
                    end else begin
                        state_d = FRAME;
                    end
                end else begin
                    // Stray mid-frame words are flushed; an early SOP is held off.
                    ready_c   = avtx.valid && !avtx.startofpacket;
                    drop_d    = ready_c;
                    tx_data_d = fill_data;
                    rrdy_emit = fill_rrdy;
                    gap_d     = gap_step;
                end
            end

            FRAME: begin
                ready_c = 1'b1;
                if (!link_active) begin
                    drop_d  = avtx.valid;
                    gap_d   = gap_step;
                    state_d = (avtx.valid && avtx.endofpacket) ? FILL : DRAIN;
                end else if (!avtx.valid) begin
                    underrun_d = 1'b1;
                end else begin
                    tx_data_d  = avtx.data;
                    tx_datak_d = (avtx.startofpacket || avtx.endofpacket) ? K_FILL : K_DATA;
                    if (avtx.endofpacket) begin
                        state_d  = FILL;
                        frames_d = frames_q + 32'd1;
                    end
                end
            end

            DRAIN: begin
                ready_c   = 1'b1;
                drop_d    = avtx.valid;
                tx_data_d = fill_data;
                rrdy_emit = fill_rrdy;
                gap_d     = gap_step;
                if (avtx.valid && avtx.endofpacket) begin
                    state_d = FILL;
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            gap_q      <= '0;
            tx_data_q  <= IDLE_WORD;
            tx_datak_q <= K_FILL;
            underrun_q <= 1'b0;
            drop_q     <= 1'b0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_datak_q <= tx_datak_d;
            underrun_q <= underrun_d;
            drop_q     <= drop_d;
            frames_q   <= frames_d;
        end
    end

    assign avtx.ready  = ready_c;
    assign tx_data     = tx_data_q;
    assign tx_datak    = tx_datak_q;
    assign underrun    = underrun_q;
    assign drop        = drop_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_fc_tx_sched.sv
// Directed bench for fc_tx_sched: idle fill, frame spacing, R_RDY credit, underrun,
// link drop and asynchronous reset, each word checked against hand-computed values.
module tb_fc_tx_sched;
    import fc_tx_sched_pkg::*;

    localparam int MIN_FILL = 6;
    localparam int RRDY_W   = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              link_active = 1'b0;
    logic              rrdy_req = 1'b0;
    logic [RRDY_W-1:0] rrdy_pending;
    logic [31:0]       tx_data;
    logic [3:0]        tx_datak;
    logic              underrun;
    logic              drop;
    logic [31:0]       frames_sent;

    fc_tx_sched_if avtx_bus ();

    fc_tx_sched #(
        .MIN_FILL (MIN_FILL),
        .RRDY_W   (RRDY_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .link_active  (link_active),
        .avtx         (avtx_bus),
        .rrdy_req     (rrdy_req),
        .rrdy_pending (rrdy_pending),
        .tx_data      (tx_data),
        .tx_datak     (tx_datak),
        .underrun     (underrun),
        .drop         (drop),
        .frames_sent  (frames_sent)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int exp_frames = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("  ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input int f, input int i);
        return {8'hD0, 8'(f), 16'(i)};
    endfunction

    // Present one word until accepted; on_line says whether it should reach tx_data.
    task automatic send_word(input string tag, input logic [31:0] w, input logic s, input logic e,
                             input logic req, input logic on_line,
                             output int waits, output int non_idle);
        waits    = 0;
        non_idle = 0;
        avtx_bus.data          = w;
        avtx_bus.valid         = 1'b1;
        avtx_bus.startofpacket = s;
        avtx_bus.endofpacket   = e;
        rrdy_req               = req;
        @(negedge clk);
        while (avtx_bus.ready !== 1'b1 && waits < 40) begin
            @(posedge clk);
            #1;
            waits++;
            if (tx_data !== IDLE_WORD || tx_datak !== K_FILL) non_idle++;
            @(negedge clk);
        end
        check_vec($sformatf("%s.ready", tag), 32'(avtx_bus.ready), 32'd1);
        @(posedge clk);
        #1;
        avtx_bus.valid         = 1'b0;
        avtx_bus.startofpacket = 1'b0;
        avtx_bus.endofpacket   = 1'b0;
        rrdy_req               = 1'b0;
        if (on_line) begin
            if (e) exp_frames++;
            check_vec($sformatf("%s.data", tag), tx_data, w);
            check_vec($sformatf("%s.k", tag), 32'(tx_datak), 32'((s || e) ? K_FILL : K_DATA));
        end else begin
            check_vec($sformatf("%s.data", tag), tx_data, IDLE_WORD);
            check_vec($sformatf("%s.drop", tag), 32'(drop), 32'd1);
        end
        check_vec($sformatf("%s.frames", tag), frames_sent, 32'(exp_frames));
    endtask

    initial begin : stim
        int waits;
        int non_idle;
        logic [31:0] exp_seq [4];
        logic [31:0] exp_pend [4];

        avtx_bus.data          = '0;
        avtx_bus.valid         = 1'b0;
        avtx_bus.startofpacket = 1'b0;
        avtx_bus.endofpacket   = 1'b0;
        link_active            = 1'b1;
        reset_n                = 1'b0;
        repeat (3) tick();

        check_vec("rst.tx_data", tx_data, 32'hBC95B5B5);
        check_vec("rst.tx_datak", 32'(tx_datak), 32'h8);
        check_vec("rst.ready", 32'(avtx_bus.ready), 32'd0);
        check_vec("rst.pending", 32'(rrdy_pending), 32'd0);
        check_vec("rst.underrun", 32'(underrun), 32'd0);
        check_vec("rst.drop", 32'(drop), 32'd0);
        check_vec("rst.frames", frames_sent, 32'd0);
        reset_n = 1'b1;

        // Idle link
        for (int i = 0; i < 8; i++) begin
            tick();
            check_vec($sformatf("idle%0d.tx", i), tx_data, 32'hBC95B5B5);
            check_vec($sformatf("idle%0d.k", i), 32'(tx_datak), 32'h8);
            check_vec($sformatf("idle%0d.pend", i), 32'(rrdy_pending), 32'd0);
        end

        // Back-to-back 4-word frames
        for (int i = 0; i < 4; i++) begin
            send_word($sformatf("A%0d", i), wd(1, i), i == 0, i == 3, 1'b0, 1'b1, waits, non_idle);
            if (i == 0) check_vec("A0.waits", 32'(waits), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            send_word($sformatf("B%0d", i), wd(2, i), i == 0, i == 3, 1'b0, 1'b1, waits, non_idle);
            if (i == 0) begin
                check_vec("B0.gap_words", 32'(waits), 32'd6);
                check_vec("B0.gap_non_idle", 32'(non_idle), 32'd0);
            end
        end
        check_vec("B.frames_sent", frames_sent, 32'd2);

        // R_RDY requests during a 10-word frame
        for (int i = 0; i < 10; i++) begin
            send_word($sformatf("C%0d", i), wd(3, i), i == 0, i == 9, (i == 1 || i == 3 || i == 5),
                      1'b1, waits, non_idle);
            if (i == 0) check_vec("C0.gap_words", 32'(waits), 32'd6);
        end
        check_vec("C.pending_at_eof", 32'(rrdy_pending), 32'd3);
        exp_seq  = '{32'hBC954A4A, 32'hBC954A4A, 32'hBC954A4A, 32'hBC95B5B5};
        exp_pend = '{32'd2, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec($sformatf("Cfill%0d.tx", i), tx_data, exp_seq[i]);
            check_vec($sformatf("Cfill%0d.pend", i), 32'(rrdy_pending), exp_pend[i]);
        end

        // Request coinciding with an R_RDY emission
        rrdy_req = 1'b1;
        tick();
        rrdy_req = 1'b0;
        check_vec("sim0.tx", tx_data, IDLE_WORD);
        check_vec("sim0.pend", 32'(rrdy_pending), 32'd1);
        rrdy_req = 1'b1;
        tick();
        rrdy_req = 1'b0;
        check_vec("sim1.tx", tx_data, RRDY_WORD);
        check_vec("sim1.pend", 32'(rrdy_pending), 32'd1);
        tick();
        check_vec("sim2.tx", tx_data, RRDY_WORD);
        check_vec("sim2.pend", 32'(rrdy_pending), 32'd0);
        tick();
        check_vec("sim3.tx", tx_data, IDLE_WORD);

        // Saturation: 256 requests while a frame is stalled
        send_word("D0", wd(4, 0), 1'b1, 1'b0, 1'b0, 1'b1, waits, non_idle);
        rrdy_req = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 0 || i == 255) begin
                check_vec($sformatf("Dstall%0d.underrun", i), 32'(underrun), 32'd1);
                check_vec($sformatf("Dstall%0d.tx", i), tx_data, IDLE_WORD);
            end
        end
        rrdy_req = 1'b0;
        check_vec("D.pend_sat", 32'(rrdy_pending), 32'd255);
        send_word("D1", wd(4, 1), 1'b0, 1'b0, 1'b0, 1'b1, waits, non_idle);
        send_word("D2", wd(4, 2), 1'b0, 1'b1, 1'b0, 1'b1, waits, non_idle);
        tick();
        check_vec("Dpost.tx", tx_data, RRDY_WORD);
        check_vec("Dpost.pend", 32'(rrdy_pending), 32'd254);
        link_active = 1'b0;
        tick();
        link_active = 1'b1;
        check_vec("Dlinkdown.tx", tx_data, IDLE_WORD);
        check_vec("Dlinkdown.pend", 32'(rrdy_pending), 32'd0);

        // Underrun: valid low for 2 cycles mid-frame
        send_word("E0", wd(5, 0), 1'b1, 1'b0, 1'b0, 1'b1, waits, non_idle);
        send_word("E1", wd(5, 1), 1'b0, 1'b0, 1'b0, 1'b1, waits, non_idle);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_vec($sformatf("Egap%0d.underrun", i), 32'(underrun), 32'd1);
            check_vec($sformatf("Egap%0d.tx", i), tx_data, IDLE_WORD);
            check_vec($sformatf("Egap%0d.k", i), 32'(tx_datak), 32'h8);
        end
        send_word("E2", wd(5, 2), 1'b0, 1'b0, 1'b0, 1'b1, waits, non_idle);
        check_vec("E2.underrun", 32'(underrun), 32'd0);
        send_word("E3", wd(5, 3), 1'b0, 1'b1, 1'b0, 1'b1, waits, non_idle);

        // Link drop at word 3 of an 8-word frame
        send_word("F0", wd(6, 0), 1'b1, 1'b0, 1'b0, 1'b1, waits, non_idle);
        send_word("F1", wd(6, 1), 1'b0, 1'b0, 1'b1, 1'b1, waits, non_idle);
        send_word("F2", wd(6, 2), 1'b0, 1'b0, 1'b0, 1'b1, waits, non_idle);
        check_vec("F.pend_before", 32'(rrdy_pending), 32'd1);
        link_active = 1'b0;
        for (int i = 3; i < 8; i++) begin
            send_word($sformatf("F%0d", i), wd(6, i), 1'b0, i == 7, 1'b0, 1'b0, waits, non_idle);
            if (i == 3) check_vec("F3.pend_cleared", 32'(rrdy_pending), 32'd0);
        end
        link_active = 1'b1;

        // Single-word frame after the drain
        send_word("G0", wd(7, 0), 1'b1, 1'b1, 1'b0, 1'b1, waits, non_idle);
        tick();
        check_vec("Gpost.tx", tx_data, IDLE_WORD);
        check_vec("Gpost.underrun", 32'(underrun), 32'd0);

        // Asynchronous reset mid-frame
        send_word("H0", wd(8, 0), 1'b1, 1'b0, 1'b0, 1'b1, waits, non_idle);
        send_word("H1", wd(8, 1), 1'b0, 1'b0, 1'b1, 1'b1, waits, non_idle);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("arst.tx", tx_data, IDLE_WORD);
        check_vec("arst.k", 32'(tx_datak), 32'h8);
        check_vec("arst.frames", frames_sent, 32'd0);
        check_vec("arst.pend", 32'(rrdy_pending), 32'd0);
        exp_frames = 0;
        tick();
        reset_n = 1'b1;

        // Stray non-SOP word in FILL is consumed and dropped
        send_word("stray", wd(9, 0), 1'b0, 1'b0, 1'b0, 1'b0, waits, non_idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
